// File: rtl/gauss_window_feeder.sv
// gauss_window_feeder
//   Accepts a raster-order RGB stream, keeps three rows in a ring of line
//   buffers and replays every output position's 3x3 neighbourhood as 9 serial
//   beats, zero-padding neighbours that fall outside the image.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_rgb_vld/data/busy upstream pixel handshake (busy is an output)
//   o_rgb_vld/data/busy downstream beat handshake (busy is an input)
//   o_frame_done        one-cycle pulse after the last beat of a frame
//
// Row schedule: ACCEPT(0), ACCEPT(1), EMIT(0), ACCEPT(2), EMIT(1), ...,
// ACCEPT(H-1), EMIT(H-2), EMIT(H-1), frame_done.
module gauss_window_feeder #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rgb_vld,
    input  logic [23:0] i_rgb_data,
    output logic        i_rgb_busy,
    output logic        o_rgb_vld,
    output logic [23:0] o_rgb_data,
    input  logic        o_rgb_busy,
    output logic        o_frame_done
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    localparam logic [YW-1:0] Y_PEN  = YW'(HEIGHT - 2);

    typedef enum logic {S_ACCEPT, S_EMIT} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   wx_q, wx_d;         // input column
    logic [YW-1:0]   r_q, r_d;           // row being accepted
    logic [1:0]      ws_q, ws_d;         // r mod 3
    logic [YW-1:0]   y_q, y_d;           // row being emitted
    logic [1:0]      ys_q, ys_d;         // y mod 3
    logic [XW-1:0]   ex_q, ex_d;         // column of the next beat to generate
    logic [3:0]      beat_q, beat_d;     // 0..8 within the window
    logic            gen_done_q, gen_done_d;
    logic            vld_q, vld_d;
    logic [23:0]     data_q, data_d;
    logic            done_q, done_d;

    // Line buffer ring; plain RAM, no reset needed since every row read in a
    // frame is written earlier in that same frame.
    logic [23:0]     mem_q [3][WIDTH];

    logic            in_xfer, out_xfer, load;
    logic [1:0]      row_sel, col_sel, rd_slot;
    logic [XW-1:0]   rd_col;
    logic            pad;
    logic [23:0]     beat_pix;

    function automatic logic [1:0] slot_inc(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    function automatic logic [1:0] slot_dec(input logic [1:0] s);
        return (s == 2'd0) ? 2'd2 : s - 2'd1;
    endfunction

    assign in_xfer  = (state_q == S_ACCEPT) && i_rgb_vld;
    assign out_xfer = vld_q && !o_rgb_busy;
    // Output register may take a new beat when empty or being drained now.
    assign load     = !vld_q || !o_rgb_busy;

    // Neighbour address / padding for the beat about to be generated.
    // Padding is decided by equality against the edges, so no index ever
    // has to go below 0 or beyond the last row/column.
    always_comb begin
        row_sel = 2'd0;
        col_sel = 2'd0;
        case (beat_q)
            4'd0: begin row_sel = 2'd0; col_sel = 2'd0; end
            4'd1: begin row_sel = 2'd0; col_sel = 2'd1; end
            4'd2: begin row_sel = 2'd0; col_sel = 2'd2; end
            4'd3: begin row_sel = 2'd1; col_sel = 2'd0; end
            4'd4: begin row_sel = 2'd1; col_sel = 2'd1; end
            4'd5: begin row_sel = 2'd1; col_sel = 2'd2; end
            4'd6: begin row_sel = 2'd2; col_sel = 2'd0; end
            4'd7: begin row_sel = 2'd2; col_sel = 2'd1; end
            default: begin row_sel = 2'd2; col_sel = 2'd2; end
        endcase

        pad = ((row_sel == 2'd0) && (y_q  == '0))     ||
              ((row_sel == 2'd2) && (y_q  == Y_LAST)) ||
              ((col_sel == 2'd0) && (ex_q == '0))     ||
              ((col_sel == 2'd2) && (ex_q == X_LAST));

        rd_slot = ys_q;
        if (row_sel == 2'd0) rd_slot = slot_dec(ys_q);
        if (row_sel == 2'd2) rd_slot = slot_inc(ys_q);

        // Padded beats keep the in-range column so the read stays in bounds.
        rd_col = ex_q;
        if (!pad && col_sel == 2'd0) rd_col = ex_q - 1'b1;
        if (!pad && col_sel == 2'd2) rd_col = ex_q + 1'b1;

        beat_pix = pad ? 24'h000000 : mem_q[rd_slot][rd_col];
    end

    always_comb begin
        state_d    = state_q;
        wx_d       = wx_q;
        r_d        = r_q;
        ws_d       = ws_q;
        y_d        = y_q;
        ys_d       = ys_q;
        ex_d       = ex_q;
        beat_d     = beat_q;
        gen_done_d = gen_done_q;
        vld_d      = vld_q;
        data_d     = data_q;
        done_d     = 1'b0;

        case (state_q)
            S_ACCEPT: begin
                if (in_xfer) begin
                    if (wx_q == X_LAST) begin
                        wx_d = '0;
                        ws_d = slot_inc(ws_q);
                        r_d  = (r_q == Y_LAST) ? '0 : r_q + 1'b1;
                        // Row 0 alone cannot produce a window; wait for row 1.
                        if (r_q != '0) state_d = S_EMIT;
                    end else begin
                        wx_d = wx_q + 1'b1;
                    end
                end
            end
            default: begin
                if (load) begin
                    if (!gen_done_q) begin
                        vld_d  = 1'b1;
                        data_d = beat_pix;
                        if (beat_q == 4'd8) begin
                            beat_d = '0;
                            if (ex_q == X_LAST) begin
                                ex_d       = '0;
                                gen_done_d = 1'b1;
                            end else begin
                                ex_d = ex_q + 1'b1;
                            end
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end else begin
                        vld_d = 1'b0;
                    end
                end
                // Row ends when its final beat leaves the output register.
                if (gen_done_q && out_xfer) begin
                    gen_done_d = 1'b0;
                    ys_d       = slot_inc(ys_q);
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        ys_d    = 2'd0;
                        ws_d    = 2'd0;
                        r_d     = '0;
                        done_d  = 1'b1;
                        state_d = S_ACCEPT;
                    end else begin
                        y_d     = y_q + 1'b1;
                        // Last two rows are emitted back to back.
                        state_d = (y_q == Y_PEN) ? S_EMIT : S_ACCEPT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_ACCEPT;
            wx_q       <= '0;
            r_q        <= '0;
            ws_q       <= 2'd0;
            y_q        <= '0;
            ys_q       <= 2'd0;
            ex_q       <= '0;
            beat_q     <= '0;
            gen_done_q <= 1'b0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wx_q       <= wx_d;
            r_q        <= r_d;
            ws_q       <= ws_d;
            y_q        <= y_d;
            ys_q       <= ys_d;
            ex_q       <= ex_d;
            beat_q     <= beat_d;
            gen_done_q <= gen_done_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && in_xfer) mem_q[ws_q][wx_q] <= i_rgb_data;
    end

    assign i_rgb_busy   = (state_q == S_EMIT);
    assign o_rgb_vld    = vld_q;
    assign o_rgb_data   = data_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_gauss_window_feeder.sv
// Bench for gauss_window_feeder: two instances (4x3 and 2x2), a frame-level
// reference model, hand-computed beat table and handshake/timing checks.
module tb_gauss_window_feeder;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        in_vld   [2];
    logic [23:0] in_data  [2];
    logic        in_busy  [2];
    logic        out_vld  [2];
    logic [23:0] out_data [2];
    logic        out_busy [2];
    logic        done     [2];

    int WW [2] = '{4, 2};
    int HH [2] = '{3, 2};

    int n_chk  = 0;
    int n_fail = 0;
    int tot_done;

    logic [23:0] pix_q [$];
    logic [23:0] exp_q [$];
    logic [23:0] got_q [$];

    typedef struct {
        int          dut;
        int          idx;
        logic [23:0] exp;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    gauss_window_feeder #(.WIDTH(4), .HEIGHT(3)) u_a (
        .i_clk(clk), .i_rst(rst[0]),
        .i_rgb_vld(in_vld[0]), .i_rgb_data(in_data[0]), .i_rgb_busy(in_busy[0]),
        .o_rgb_vld(out_vld[0]), .o_rgb_data(out_data[0]), .o_rgb_busy(out_busy[0]),
        .o_frame_done(done[0]));

    gauss_window_feeder #(.WIDTH(2), .HEIGHT(2)) u_b (
        .i_clk(clk), .i_rst(rst[1]),
        .i_rgb_vld(in_vld[1]), .i_rgb_data(in_data[1]), .i_rgb_busy(in_busy[1]),
        .o_rgb_vld(out_vld[1]), .o_rgb_data(out_data[1]), .o_rgb_busy(out_busy[1]),
        .o_frame_done(done[1]));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // mode 0: P(x,y) = {y, x, 5A} ^ mask; mode 1: random pixels
    task automatic fill_pix(input int d, input int mode, input logic [23:0] mask);
        pix_q = {};
        for (int y = 0; y < HH[d]; y++)
            for (int x = 0; x < WW[d]; x++)
                if (mode == 0) pix_q.push_back({y[7:0], x[7:0], 8'h5A} ^ mask);
                else           pix_q.push_back(24'($urandom));
    endtask

    // Every output position, every neighbour, zero outside the image.
    task automatic build_model(input int d);
        int w, h, xx, yy;
        w = WW[d];
        h = HH[d];
        exp_q = {};
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++)
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++) begin
                        yy = y + dy;
                        xx = x + dx;
                        if (yy < 0 || yy >= h || xx < 0 || xx >= w) exp_q.push_back(24'h0);
                        else exp_q.push_back(pix_q[yy * w + xx]);
                    end
    endtask

    task automatic step(input int d, input logic sv, input logic [23:0] sd, input logic sb);
        @(negedge clk);
        in_vld[d]   = sv;
        in_data[d]  = sd;
        out_busy[d] = sb;
        #1;
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d]      = 1'b1;
        in_vld[d]   = 1'b0;
        out_busy[d] = 1'b0;
        @(negedge clk);
        rst[d] = 1'b0;
        #1;
    endtask

    // Push pix_q into DUT d and collect beats into got_q. stop_beats > 0
    // abandons the frame after that many beats (no end-of-frame checks).
    task automatic run_frame(input int d, input int busy_pct, input int gap_pct, input int stop_beats);
        int w, h, k, cyc, beats, rows_done, dones, last_in;
        logic sv, sb, prev_hold, wait_first, chk_rise, chk_fall, fin;
        logic [23:0] prev_data;
        w = WW[d]; h = HH[d];
        k = 0; cyc = 0; beats = 0; rows_done = 0; dones = 0; last_in = 0;
        prev_hold = 0; wait_first = 0; chk_rise = 0; chk_fall = 0; fin = 0;
        prev_data = '0;
        got_q = {};
        build_model(d);
        while (!fin && cyc < 5000) begin
            sv = (k < w * h) && ($urandom_range(99) >= gap_pct);
            sb = ($urandom_range(99) < busy_pct);
            step(d, sv, sv ? pix_q[k] : 24'($urandom), sb);
            if (prev_hold) begin
                check("hold_vld", 32'(out_vld[d]), 32'd1);
                check("hold_data", 32'(out_data[d]), 32'(prev_data));
            end
            if (chk_rise) check("busy_rise", 32'(in_busy[d]), 32'd1);
            if (chk_fall) check("busy_fall", 32'(in_busy[d]), 32'd0);
            chk_rise = 0;
            chk_fall = 0;
            if (out_vld[d]) check("busy_in_emit", 32'(in_busy[d]), 32'd1);
            if (wait_first && out_vld[d]) begin
                check("emit_latency", 32'(cyc - last_in <= 2), 32'd1);
                wait_first = 0;
            end
            if (busy_pct == 0 && in_busy[d] && beats % (9 * w) != 0)
                check("sustained", 32'(out_vld[d]), 32'd1);
            if (done[d]) begin
                dones++;
                tot_done++;
                check("done_after_last", 32'(beats), 32'(9 * w * h));
                step(d, 1'b0, 24'h0, 1'b0);
                check("done_width", 32'(done[d]), 32'd0);
                fin = 1;
            end else begin
                if (sv && !in_busy[d]) begin
                    k++;
                    last_in = cyc;
                    if (k % w == 0 && k / w >= 2) begin
                        chk_rise   = 1;
                        wait_first = 1;
                    end
                end
                if (out_vld[d] && !sb) begin
                    got_q.push_back(out_data[d]);
                    beats++;
                    if (beats % (9 * w) == 0) begin
                        rows_done++;
                        if (rows_done != h - 1) chk_fall = 1;
                    end
                end
                prev_hold = out_vld[d] && sb;
                prev_data = out_data[d];
                if (stop_beats > 0 && beats >= stop_beats) return;
            end
            cyc++;
        end
        check("frame_timeout", 32'(fin), 32'd1);
        check("frame_done_count", 32'(dones), 32'd1);
        check("inputs_taken", 32'(k), 32'(w * h));
        check("beat_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("beat[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic apply_table(input int d);
        for (int i = 0; i < tbl.size(); i++)
            if (tbl[i].dut == d)
                check($sformatf("tbl_d%0d[%0d]", d, tbl[i].idx),
                      32'(got_q[tbl[i].idx]), 32'(tbl[i].exp));
    endtask

    initial begin
        // 4x3: window (0,0) and window (3,2); 2x2: window (1,1)
        tbl.push_back('{0, 0, 24'h000000});   tbl.push_back('{0, 1, 24'h000000});
        tbl.push_back('{0, 2, 24'h000000});   tbl.push_back('{0, 3, 24'h000000});
        tbl.push_back('{0, 4, 24'h00005A});   tbl.push_back('{0, 5, 24'h00015A});
        tbl.push_back('{0, 6, 24'h000000});   tbl.push_back('{0, 7, 24'h01005A});
        tbl.push_back('{0, 8, 24'h01015A});
        tbl.push_back('{0, 99, 24'h01025A});  tbl.push_back('{0, 100, 24'h01035A});
        tbl.push_back('{0, 101, 24'h000000}); tbl.push_back('{0, 102, 24'h02025A});
        tbl.push_back('{0, 103, 24'h02035A}); tbl.push_back('{0, 104, 24'h000000});
        tbl.push_back('{0, 105, 24'h000000}); tbl.push_back('{0, 106, 24'h000000});
        tbl.push_back('{0, 107, 24'h000000});
        tbl.push_back('{1, 27, 24'h00005A});  tbl.push_back('{1, 28, 24'h00015A});
        tbl.push_back('{1, 29, 24'h000000});  tbl.push_back('{1, 30, 24'h01005A});
        tbl.push_back('{1, 31, 24'h01015A});  tbl.push_back('{1, 32, 24'h000000});
        tbl.push_back('{1, 33, 24'h000000});  tbl.push_back('{1, 34, 24'h000000});
        tbl.push_back('{1, 35, 24'h000000});

        tot_done = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_vld[d] = 1'b0; in_data[d] = '0; out_busy[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) rst[d] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_in_busy", 32'(in_busy[d]), 32'd0);
            check("rst_out_vld", 32'(out_vld[d]), 32'd0);
            check("rst_out_data", 32'(out_data[d]), 32'd0);
            check("rst_done", 32'(done[d]), 32'd0);
        end

        // 4x3 basic frame, continuous source, idle sink
        fill_pix(0, 0, 24'h0);
        run_frame(0, 0, 0, 0);
        apply_table(0);
        // same frame under 50% sink backpressure
        run_frame(0, 50, 0, 0);
        apply_table(0);
        // random pixels, random source gaps and sink stalls
        for (int n = 0; n < 3; n++) begin
            fill_pix(0, 1, 24'h0);
            run_frame(0, 30, 30, 0);
        end

        // 2x2 minimum size
        fill_pix(1, 0, 24'h0);
        run_frame(1, 0, 0, 0);
        apply_table(1);
        fill_pix(1, 1, 24'h0);
        run_frame(1, 50, 20, 0);

        // reset in the middle of EMIT(1), then a fresh, distinct frame
        fill_pix(0, 0, 24'h0);
        run_frame(0, 0, 0, 40);
        do_reset(0);
        check("midrst_out_vld", 32'(out_vld[0]), 32'd0);
        check("midrst_in_busy", 32'(in_busy[0]), 32'd0);
        fill_pix(0, 0, 24'hFFFFFF);
        run_frame(0, 20, 0, 0);

        // back-to-back frames with complementary contents
        tot_done = 0;
        fill_pix(0, 0, 24'h0);
        run_frame(0, 0, 0, 0);
        fill_pix(0, 0, 24'hFFFFFF);
        run_frame(0, 0, 0, 0);
        check("b2b_done_pulses", 32'(tot_done), 32'd2);
        check("b2b_top_row_zero", 32'(got_q[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
